// File: rtl/div_job_controller_if.sv
// Bundles the job-in, divider and result-out handshakes of div_job_controller.
// The master modport is the controller's view; slave is the surrounding system.
interface div_job_controller_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [15:0]      in_b;
  logic [TAG_W-1:0] in_tag;

  logic             div_start;
  logic [31:0]      div_a;
  logic [15:0]      div_b;
  logic             div_busy;
  logic             div_ready;
  logic [31:0]      div_q;
  logic [15:0]      div_r;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_q;
  logic [15:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_dz;
  logic             out_err;

  modport master (
    input  in_valid, in_a, in_b, in_tag,
    input  div_busy, div_ready, div_q, div_r,
    input  out_ready,
    output in_ready,
    output div_start, div_a, div_b,
    output out_valid, out_q, out_r, out_tag, out_dz, out_err
  );

  modport slave (
    output in_valid, in_a, in_b, in_tag,
    output div_busy, div_ready, div_q, div_r,
    output out_ready,
    input  in_ready,
    input  div_start, div_a, div_b,
    input  out_valid, out_q, out_r, out_tag, out_dz, out_err
  );
endinterface

// File: rtl/div_job_controller.sv
// Job wrapper for the 32/16 divider: FIFO-buffered operand jobs, one divide in
// flight, divide-by-zero bypass and hung-divider timeout, tagged results out.
//
// state     | meaning
// IDLE      | waiting for a queued job; pops the head when one is present
// LAUNCH    | one-cycle div_start pulse, timeout counter cleared
// WAIT_BUSY | waiting for the divider to raise busy (ready ignored)
// WAIT_DONE | waiting for busy low with ready high, then captures q/r
// RESULT    | out_valid held until the consumer accepts
module div_job_controller #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    clear,
  div_job_controller_if.master    bus,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESULT} state_t;
  state_t state, state_nx;

  logic [31:0]      fa [DEPTH];
  logic [15:0]      fb [DEPTH];
  logic [TAG_W-1:0] ft [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, div_done, timed_out;
  logic [TW-1:0]    to_cnt;

  logic [TAG_W-1:0] job_tag;
  logic [31:0]      div_a_q, out_q_q;
  logic [15:0]      div_b_q, out_r_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             out_dz_q, out_err_q;

  assign bus.in_ready = (count < FULL_C);
  assign push         = bus.in_valid && bus.in_ready;
  assign fifo_count   = count;
  assign div_done     = !bus.div_busy && bus.div_ready;
  assign timed_out    = (to_cnt == TO_LAST);

  assign bus.div_a   = div_a_q;
  assign bus.div_b   = div_b_q;
  assign bus.out_q   = out_q_q;
  assign bus.out_r   = out_r_q;
  assign bus.out_tag = out_tag_q;
  assign bus.out_dz  = out_dz_q;
  assign bus.out_err = out_err_q;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    pop           = 1'b0;
    bus.div_start = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          state_nx = (fb[rd_ptr] == '0) ? RESULT : LAUNCH;
        end
      end
      LAUNCH: begin
        bus.div_start = 1'b1;
        state_nx      = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (timed_out)         state_nx = RESULT;
        else if (bus.div_busy) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (div_done || timed_out) state_nx = RESULT;
      end
      RESULT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Storage is not reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fa[wr_ptr] <= bus.in_a;
      fb[wr_ptr] <= bus.in_b;
      ft[wr_ptr] <= bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      to_cnt    <= '0;
      job_tag   <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      out_q_q   <= '0;
      out_r_q   <= '0;
      out_tag_q <= '0;
      out_dz_q  <= 1'b0;
      out_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      case (state)
        IDLE: begin
          if (pop) begin
            if (fb[rd_ptr] == '0) begin
              out_q_q   <= '1;
              out_r_q   <= '1;
              out_tag_q <= ft[rd_ptr];
              out_dz_q  <= 1'b1;
              out_err_q <= 1'b0;
            end else begin
              div_a_q <= fa[rd_ptr];
              div_b_q <= fb[rd_ptr];
              job_tag <= ft[rd_ptr];
            end
          end
        end
        LAUNCH: to_cnt <= '0;
        WAIT_BUSY, WAIT_DONE: begin
          to_cnt <= to_cnt + TW'(1);
          // A genuine completion wins over a timeout landing on the same cycle.
          if (state == WAIT_DONE && div_done) begin
            out_q_q   <= bus.div_q;
            out_r_q   <= bus.div_r;
            out_tag_q <= job_tag;
            out_dz_q  <= 1'b0;
            out_err_q <= 1'b0;
          end else if (timed_out) begin
            out_q_q   <= '0;
            out_r_q   <= '0;
            out_tag_q <= job_tag;
            out_dz_q  <= 1'b0;
            out_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_job_controller.sv
// Randomized scoreboard bench for div_job_controller with a behavioural divider
// model that hangs on a marker dividend and leaves ready high between jobs.
module tb_div_job_controller;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] HANG_A = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic [$clog2(DEPTH):0] fifo_count;

  div_job_controller_if #(.TAG_W(TAG_W)) bus ();

  div_job_controller #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .clear      (clear),
    .bus        (bus),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      q;
    logic [15:0]      r;
    logic [TAG_W-1:0] tag;
    logic             dz;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int or_mode = 1;
  int n_starts = 0;
  int n_launched_res = 0;
  int ready_cyc = -1;
  int hang_cyc = -1;
  int first_cyc = -1;
  int busy_min = 1;
  int epoch = 0;
  bit fresh = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: what the job should produce, from the arithmetic alone.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b,
                                 input logic [TAG_W-1:0] t);
    exp_t e;
    e.tag = t; e.dz = 1'b0; e.err = 1'b0;
    if (b == 16'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = 16'hFFFF; e.dz = 1'b1;
    end else if (a == HANG_A) begin
      e.q = 32'd0; e.r = 16'd0; e.err = 1'b1;
    end else begin
      e.q = a / {16'd0, b};
      e.r = 16'(a % {16'd0, b});
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_a();
    logic [31:0] v;
    v = $urandom;
    if (v == HANG_A) v = 32'h1;
    return v;
  endfunction

  function automatic logic [15:0] rand_b();
    logic [15:0] v;
    v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
    if (v == 16'd0) v = 16'd7;
    return v;
  endfunction

  // Divider model: random delay to busy, random busy length, ready left high.
  initial begin
    logic [31:0] a;
    logic [15:0] b;
    int my_epoch;
    bus.div_busy = 1'b0; bus.div_ready = 1'b0; bus.div_q = '0; bus.div_r = '0;
    forever begin
      @(negedge clk);
      if (bus.div_start === 1'b1) begin
        n_starts++;
        a = bus.div_a; b = bus.div_b; my_epoch = epoch;
        if (a == HANG_A) hang_cyc = cyc;
        else begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          bus.div_busy = 1'b1; bus.div_ready = 1'b0;
          bus.div_q = $urandom; bus.div_r = 16'($urandom);
          repeat ($urandom_range(busy_min, 30)) @(negedge clk);
          if (my_epoch == epoch) begin
            chk("div_a_stable", bus.div_a, a);
            chk("div_b_stable", bus.div_b, b);
          end
          bus.div_busy = 1'b0; bus.div_ready = 1'b1;
          bus.div_q = a / {16'd0, b}; bus.div_r = 16'(a % {16'd0, b});
          ready_cyc = cyc;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: every cycle with out_valid is compared against the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!clear && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_result: got tag %0h, expected no result", bus.out_tag);
      end else begin
        e = exp_q[0];
        chk("out_q", bus.out_q, e.q);
        chk("out_r", bus.out_r, e.r);
        chk("out_tag", bus.out_tag, e.tag);
        chk("out_dz", bus.out_dz, e.dz);
        chk("out_err", bus.out_err, e.err);
        if (fresh) begin
          fresh = 1'b0;
          first_cyc = cyc;
          if (e.err)      chk("timeout_latency", cyc - hang_cyc, TIMEOUT + 1);
          else if (!e.dz) chk("ready_to_valid", cyc - ready_cyc, 1);
        end
        if (bus.out_ready === 1'b1) begin
          e = exp_q.pop_front();
          fresh = 1'b1;
          if (!e.dz) n_launched_res++;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [15:0] b,
                      input logic [TAG_W-1:0] t, output int acc);
    int n;
    n = 0; acc = -1;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_tag = t;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back(model(a, b, t));
        acc = cyc;
        break;
      end
      n++;
      if (n > 2000) begin
        n_checks++; n_errors++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, expected high", n);
        break;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    idle_wait(2);
  endtask

  initial begin
    int acc, t0, n;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    clear = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_div_a", bus.div_a, 0);
    chk("rst_div_b", bus.div_b, 0);
    chk("rst_out_q", bus.out_q, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_dz", bus.out_dz, 0);
    chk("rst_out_err", bus.out_err, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    idle_wait(2);

    // single directed job
    or_mode = 1;
    t0 = n_starts;
    send(32'h4C7F228A, 16'h6A0E, 4'd3, acc);
    drain(200);
    chk("single_start_pulses", n_starts - t0, 1);

    // divide by zero: no launch, result the cycle after the pop
    t0 = n_starts;
    send(32'h12345678, 16'h0000, 4'd5, acc);
    drain(50);
    chk("dz_latency", first_cyc - acc, 2);
    chk("dz_no_start", n_starts - t0, 0);

    // back-pressure: five jobs with the consumer stalled
    or_mode = 0;
    idle_wait(1);
    for (int i = 0; i < 5; i++)
      send(rand_a(), (i == 2) ? 16'd0 : rand_b(), 4'(i), acc);
    @(negedge clk);
    chk("bp_fifo_count_full", fifo_count, 4);
    chk("bp_in_ready_full", bus.in_ready, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = 32'h55; bus.in_b = 16'h3; bus.in_tag = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_refuse", bus.in_ready, 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle_wait(45);
    @(negedge clk);
    chk("bp_count_held", fifo_count, 4);
    @(posedge clk); #1;
    or_mode = 2;
    drain(800);

    // hung divider, then a normal job queued behind it
    or_mode = 1;
    send(HANG_A, 16'h1234, 4'd7, acc);
    send(rand_a(), rand_b(), 4'd8, acc);
    send(rand_a(), rand_b(), 4'd9, acc);
    drain(400);

    // clear in WAIT_DONE with two jobs still queued
    busy_min = 20;
    send(rand_a(), rand_b(), 4'd1, acc);
    send(rand_a(), rand_b(), 4'd2, acc);
    send(rand_a(), rand_b(), 4'd3, acc);
    n = 0;
    while (bus.div_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      n_checks++; n_errors++;
      $display("FAIL busy_wait_timeout: div_busy 0, expected 1");
    end
    @(posedge clk); #1;
    epoch++;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    exp_q.delete();
    fresh = 1'b1;
    @(negedge clk);
    chk("clr_fifo_count", fifo_count, 0);
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    idle_wait(60);
    busy_min = 1;

    // randomized traffic with random consumer stalls
    or_mode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      logic [15:0] b;
      a = ($urandom_range(0, 15) == 0) ? HANG_A : rand_a();
      b = ($urandom_range(0, 7) == 0) ? 16'd0 : rand_b();
      send(a, b, 4'($urandom), acc);
      idle_wait($urandom_range(0, 2));
    end
    drain(30000);

    // one abandoned launch from the clear test never produces a result
    chk("start_count", n_starts, n_launched_res + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
